// File: rtl/icache_ctrl.sv
// Fetch-side controller for a 16-line direct-mapped icache: probes the cache on each
// accepted fetch, runs a single-beat memory read on a miss, fills the line, counts hits/misses.
module icache_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [29:0]      req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_inst,
    output logic             resp_err,
    input  logic             cache_en,
    output logic [29:0]      cache_addr,
    output logic             cache_wen,
    output logic [31:0]      cache_wdata,
    input  logic             cache_is_hit,
    input  logic [31:0]      cache_rdata,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [29:0]      mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_data,
    input  logic             mem_resp_err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               req_ready_r;
    logic               resp_valid_r;
    logic               mem_req_valid_r;
    logic [29:0]        addr_r;
    logic [31:0]        inst_r;
    logic               err_r;
    logic [CNT_W-1:0]   hit_cnt_r;
    logic [CNT_W-1:0]   miss_cnt_r;
    logic               accept_s;
    logic               hit_s;
    logic               fill_s;
    logic [29:0]        cache_addr_s;
    logic [31:0]        cache_wdata_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign accept_s = req_valid & req_ready_r;
    assign hit_s    = cache_en & cache_is_hit;

    // Next-state decode and the single-cycle fill strobe.
    always_comb begin
        state_nxt_s = state_r;
        fill_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (hit_s) begin
                        state_nxt_s = RESP;
                    end else begin
                        state_nxt_s = MEM_REQ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MEM_REQ: begin
                if (mem_req_ready) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = MEM_REQ;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt_s = RESP;
                    fill_s      = cache_en & ~mem_resp_err;
                end else begin
                    state_nxt_s = MEM_WAIT;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                fill_s      = 1'b0;
            end
        endcase
    end

    // Cache address follows the incoming request while idle, the latched address otherwise.
    always_comb begin
        cache_addr_s  = addr_r;
        cache_wdata_s = 32'h0000_0000;
        if (state_r == IDLE) begin
            cache_addr_s = req_addr;
        end else begin
            cache_addr_s = addr_r;
        end
        if (fill_s) begin
            cache_wdata_s = mem_resp_data;
        end else begin
            cache_wdata_s = 32'h0000_0000;
        end
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            req_ready_r     <= 1'b0;
            resp_valid_r    <= 1'b0;
            mem_req_valid_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            req_ready_r     <= (state_nxt_s == IDLE);
            resp_valid_r    <= (state_nxt_s == RESP);
            mem_req_valid_r <= (state_nxt_s == MEM_REQ);
        end
    end

    // Fetch address, response payload and hit/miss counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_r     <= 30'h0;
            inst_r     <= 32'h0000_0000;
            err_r      <= 1'b0;
            hit_cnt_r  <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                addr_r <= req_addr;
                if (hit_s) begin
                    inst_r    <= cache_rdata;
                    err_r     <= 1'b0;
                    hit_cnt_r <= sat_inc(hit_cnt_r);
                end else begin
                    miss_cnt_r <= sat_inc(miss_cnt_r);
                end
            end
            // An error response returns a zero word so stale data never leaks to the core.
            if ((state_r == MEM_WAIT) && mem_resp_valid) begin
                inst_r <= mem_resp_err ? 32'h0000_0000 : mem_resp_data;
                err_r  <= mem_resp_err;
            end
        end
    end

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_inst     = inst_r;
    assign resp_err      = err_r;
    assign cache_addr    = cache_addr_s;
    assign cache_wen     = fill_s;
    assign cache_wdata   = cache_wdata_s;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = addr_r;
    assign hit_cnt       = hit_cnt_r;
    assign miss_cnt      = miss_cnt_r;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a behavioural 16-line cache, a latency-programmable
// memory responder and a response scoreboard.
module tb_icache_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        cache_en;
    logic [29:0] cache_addr;
    logic        cache_wen;
    logic [31:0] cache_wdata;
    logic        cache_is_hit;
    logic [31:0] cache_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [29:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data  = 32'h0;
    logic        mem_resp_err   = 1'b0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    logic        mem_ready_en;
    logic        mem_err_en;
    int          mem_lat;
    int          mem_hs_cnt = 0;
    int          fill_cnt   = 0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [29:0] pend_addr = 30'h0;

    logic [31:0] c_data [16];
    logic [25:0] c_tag  [16];
    logic        c_val  [16];

    logic [32:0] sb [$];

    icache_ctrl #(.CNT_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
        .cache_en(cache_en), .cache_addr(cache_addr), .cache_wen(cache_wen), .cache_wdata(cache_wdata),
        .cache_is_hit(cache_is_hit), .cache_rdata(cache_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memword(input logic [29:0] a);
        if (a == 30'h40) return 32'h0000_0013;
        return {a, 2'b00} ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cache model lookup
    assign cache_is_hit  = c_val[cache_addr[3:0]] && (c_tag[cache_addr[3:0]] == cache_addr[29:4]);
    assign cache_rdata   = c_data[cache_addr[3:0]];
    assign mem_req_ready = mem_ready_en;

    // Memory responder, handshake/fill counters and cache model write port.
    always @(posedge clock) begin
        mem_resp_valid <= 1'b0;
        mem_resp_err   <= 1'b0;
        if (pend) begin
            if (pend_cnt <= 1) begin
                mem_resp_valid <= 1'b1;
                mem_resp_data  <= mem_err_en ? 32'hDEAD_BEEF : memword(pend_addr);
                mem_resp_err   <= mem_err_en;
                pend           <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            pend       <= 1'b1;
            pend_cnt   <= mem_lat;
            pend_addr  <= mem_req_addr;
            mem_hs_cnt <= mem_hs_cnt + 1;
        end
        if (cache_wen) begin
            fill_cnt <= fill_cnt + 1;
            c_data[cache_addr[3:0]] <= cache_wdata;
            c_tag[cache_addr[3:0]]  <= cache_addr[29:4];
            c_val[cache_addr[3:0]]  <= 1'b1;
        end
    end

    // Scoreboard: compare every consumed response against the oldest expectation.
    always @(negedge clock) begin
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("resp_inst", {32'h0, resp_inst}, {32'h0, e[31:0]});
                chk("resp_err", {63'h0, resp_err}, {63'h0, e[32]});
            end
        end
    end

    task automatic issue(input logic [29:0] a, input logic [32:0] exp, input logic exp_hit);
        int n = 0;
        sb.push_back(exp);
        req_addr  = a;
        req_valid = 1'b1;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        chk("accept", {63'h0, req_ready}, 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        chk(exp_hit ? "hit_latency" : "miss_no_resp", {63'h0, resp_valid}, {63'h0, exp_hit});
        chk("mem_req_after_accept", {63'h0, mem_req_valid}, {63'h0, ~exp_hit});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        int h0, f0, m0, n;
        for (int i = 0; i < 16; i++) begin
            c_val[i]  = 1'b0;
            c_tag[i]  = 26'h0;
            c_data[i] = 32'h0;
        end
        reset_n = 1'b0; req_valid = 1'b0; req_addr = 30'h0; resp_ready = 1'b1;
        cache_en = 1'b1; mem_ready_en = 1'b1; mem_err_en = 1'b0; mem_lat = 3;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", {63'h0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'h0, resp_valid}, 64'd0);
        chk("rst_mem_req", {63'h0, mem_req_valid}, 64'd0);
        chk("rst_cache_wen", {63'h0, cache_wen}, 64'd0);
        chk("rst_resp_inst", {32'h0, resp_inst}, 64'd0);
        chk("rst_cnts", {hit_cnt, miss_cnt}, 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 1: cold miss with fill
        h0 = mem_hs_cnt; f0 = fill_cnt;
        issue(30'h40, {1'b0, 32'h0000_0013}, 1'b0);
        drain();
        chk("t1_miss_cnt", {32'h0, miss_cnt}, 64'd1);
        chk("t1_hit_cnt", {32'h0, hit_cnt}, 64'd0);
        chk("t1_mem_reqs", 64'(mem_hs_cnt - h0), 64'd1);
        chk("t1_fills", 64'(fill_cnt - f0), 64'd1);

        // 2: repeat fetch hits
        h0 = mem_hs_cnt;
        issue(30'h40, {1'b0, 32'h0000_0013}, 1'b1);
        drain();
        chk("t2_hit_cnt", {32'h0, hit_cnt}, 64'd1);
        chk("t2_mem_reqs", 64'(mem_hs_cnt - h0), 64'd0);

        // 3: same-index conflict pair thrashes
        m0 = miss_cnt;
        for (int i = 0; i < 4; i++) begin
            logic [29:0] a;
            a = i[0] ? 30'h110 : 30'h010;
            issue(a, {1'b0, memword(a)}, 1'b0);
            drain();
        end
        chk("t3_miss_delta", 64'(miss_cnt - m0), 64'd4);
        chk("t3_hit_cnt", {32'h0, hit_cnt}, 64'd1);

        // 4: backpressure on both memory request and core response
        mem_ready_en = 1'b0; resp_ready = 1'b0;
        issue(30'h23, {1'b0, memword(30'h23)}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t4_mreq_valid", {63'h0, mem_req_valid}, 64'd1);
            chk("t4_mreq_addr", {34'h0, mem_req_addr}, 64'h23);
        end
        @(posedge clock); #1;
        mem_ready_en = 1'b1;
        n = 0;
        while (!resp_valid && n < 50) begin
            n++;
            @(negedge clock);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t4_resp_valid", {63'h0, resp_valid}, 64'd1);
            chk("t4_resp_inst", {32'h0, resp_inst}, {32'h0, memword(30'h23)});
        end
        @(posedge clock); #1;
        resp_ready = 1'b1;
        drain();

        // 5: bus error then refetch
        mem_err_en = 1'b1; f0 = fill_cnt; h0 = mem_hs_cnt;
        issue(30'h55, {1'b1, 32'h0}, 1'b0);
        drain();
        chk("t5_no_fill", 64'(fill_cnt - f0), 64'd0);
        mem_err_en = 1'b0;
        issue(30'h55, {1'b0, memword(30'h55)}, 1'b0);
        drain();
        chk("t5_refetch_mem", 64'(mem_hs_cnt - h0), 64'd2);

        // 6: reset while waiting on memory; late response must be dropped
        mem_lat = 6; h0 = mem_hs_cnt;
        issue(30'h66, {1'b0, memword(30'h66)}, 1'b0);
        n = 0;
        while (mem_hs_cnt == h0 && n < 50) begin
            n++;
            @(posedge clock); #1;
        end
        sb.delete();
        reset_n = 1'b0;
        #1;
        chk("t6_resp_valid", {63'h0, resp_valid}, 64'd0);
        chk("t6_mem_req", {63'h0, mem_req_valid}, 64'd0);
        chk("t6_cnts", {hit_cnt, miss_cnt}, 64'd0);
        chk("t6_resp_inst", {32'h0, resp_inst}, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        f0 = fill_cnt;
        repeat (10) @(negedge clock);
        chk("t6_late_no_fill", 64'(fill_cnt - f0), 64'd0);
        chk("t6_idle_ready", {63'h0, req_ready}, 64'd1);
        @(posedge clock); #1;

        // bypass: cached address still goes to memory and never fills
        cache_en = 1'b0; mem_lat = 2; h0 = mem_hs_cnt; f0 = fill_cnt;
        issue(30'h40, {1'b0, 32'h0000_0013}, 1'b0);
        drain();
        issue(30'h40, {1'b0, 32'h0000_0013}, 1'b0);
        drain();
        chk("byp_miss_cnt", {32'h0, miss_cnt}, 64'd2);
        chk("byp_hit_cnt", {32'h0, hit_cnt}, 64'd0);
        chk("byp_mem_reqs", 64'(mem_hs_cnt - h0), 64'd2);
        chk("byp_no_fill", 64'(fill_cnt - f0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
